fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/if_id_reg.sv | 69 ++++++
 rtl/fetch_unit.sv | 102 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared front-end definitions for the fetch unit and decode.
// Contents:
//   ST_BOOT / ST_FETCH / ST_HALTED  fetch FSM state encoding
//   HALT_INSTR_DEF                  default encoding that stops fetch
//   RESET_PC_DEF                    default program counter after reset
//   FETCH_CNT_W                     width of the handshake counter
//   sat_inc_cnt()                   saturating increment for that counter
package cpu_pkg;

   localparam logic [1:0] ST_BOOT   = 2'd0;
   localparam logic [1:0] ST_FETCH  = 2'd1;
   localparam logic [1:0] ST_HALTED = 2'd2;

   localparam logic [7:0] HALT_INSTR_DEF = 8'b0111_1000;
   localparam logic [7:0] RESET_PC_DEF   = 8'h00;

   localparam int FETCH_CNT_W = 16;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [FETCH_CNT_W-1:0] sat_inc_cnt(input logic [FETCH_CNT_W-1:0] v);
      if (&v) return v;
      return v + FETCH_CNT_W'(1);
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with valid/ready hold behaviour.
// Ports:
//   clk_i, rst_i    clock, synchronous active-high reset (clears valid and data)
//   flush_i         drop the held instruction (valid clears, data left as is)
//   load_i          capture instr_i/pc_i; only meaningful when can_load_o=1
//   ready_i         downstream accepts the held instruction this cycle
//   instr_i, pc_i   instruction word and its address from the fetch stage
//   can_load_o      register is empty or being drained this cycle
//   valid_o         register holds a valid instruction
//   instr_o, pc_o   held instruction and its address
module if_id_reg
   import cpu_pkg::*;
#(
   parameter int PC_WIDTH    = 8,
   parameter int INSTR_WIDTH = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   flush_i,
   input  logic                   load_i,
   input  logic                   ready_i,
   input  logic [INSTR_WIDTH-1:0] instr_i,
   input  logic [PC_WIDTH-1:0]    pc_i,
   output logic                   can_load_o,
   output logic                   valid_o,
   output logic [INSTR_WIDTH-1:0] instr_o,
   output logic [PC_WIDTH-1:0]    pc_o
);

   logic                   valid_q, valid_d;
   logic [INSTR_WIDTH-1:0] instr_q, instr_d;
   logic [PC_WIDTH-1:0]    pc_q,    pc_d;

   assign can_load_o = !valid_q || ready_i;

   // Flush beats load; with neither, an accepted entry simply drains.
   // A stalled entry (valid, not ready) falls through and holds.
   always_comb begin
      valid_d = valid_q;
      instr_d = instr_q;
      pc_d    = pc_q;
      if (flush_i) begin
         valid_d = 1'b0;
      end else if (load_i && can_load_o) begin
         valid_d = 1'b1;
         instr_d = instr_i;
         pc_d    = pc_i;
      end else if (ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         instr_q <= '0;
         pc_q    <= '0;
      end else begin
         valid_q <= valid_d;
         instr_q <= instr_d;
         pc_q    <= pc_d;
      end
   end

   assign valid_o = valid_q;
   assign instr_o = instr_q;
   assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: program counter, BOOT/FETCH/HALTED control,
// accepted-handshake counter, and the IF/ID register.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   inst_addr           fetch address (the PC register)
//   instruction         memory data for inst_addr, same cycle
//   branch_taken        redirect request; branch_target is the new PC
//   out_ready           decode accepts the registered instruction
//   out_valid/out_instr/out_pc   IF/ID register contents
//   halted              FSM is in HALTED
//   fetch_count         saturating count of out_valid & out_ready
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int                     PC_WIDTH    = 8,
   parameter int                     INSTR_WIDTH = 8,
   parameter logic [PC_WIDTH-1:0]    RESET_PC    = PC_WIDTH'(RESET_PC_DEF),
   parameter logic [INSTR_WIDTH-1:0] HALT_INSTR  = INSTR_WIDTH'(HALT_INSTR_DEF)
) (
   input  logic                   clk,
   input  logic                   reset,
   output logic [PC_WIDTH-1:0]    inst_addr,
   input  logic [INSTR_WIDTH-1:0] instruction,
   input  logic                   branch_taken,
   input  logic [PC_WIDTH-1:0]    branch_target,
   input  logic                   out_ready,
   output logic                   out_valid,
   output logic [INSTR_WIDTH-1:0] out_instr,
   output logic [PC_WIDTH-1:0]    out_pc,
   output logic                   halted,
   output logic [15:0]            fetch_count
);

   logic [PC_WIDTH-1:0]    pc_q,    pc_d;
   logic [1:0]             state_q, state_d;
   logic [FETCH_CNT_W-1:0] cnt_q,   cnt_d;

   logic can_load;
   logic branch_ok;
   logic advance;

   // BOOT is a fixed one-cycle settle; a redirect arriving then is dropped.
   assign branch_ok = branch_taken && (state_q != ST_BOOT);
   assign advance   = (state_q == ST_FETCH) && can_load && !branch_ok;

   always_comb begin
      pc_d    = pc_q;
      state_d = state_q;
      if (state_q == ST_BOOT) begin
         state_d = ST_FETCH;
      end else if (branch_ok) begin
         pc_d    = branch_target;
         state_d = ST_FETCH;
      end else if (advance) begin
         // A HALT is still delivered downstream; only further fetch stops.
         pc_d = pc_q + PC_WIDTH'(1);
         if (instruction == HALT_INSTR) state_d = ST_HALTED;
      end else if (state_q != ST_FETCH && state_q != ST_HALTED) begin
         // Unused encoding: recover into normal fetch.
         state_d = ST_FETCH;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (out_valid && out_ready) cnt_d = sat_inc_cnt(cnt_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q    <= RESET_PC;
         state_q <= ST_BOOT;
         cnt_q   <= '0;
      end else begin
         pc_q    <= pc_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   if_id_reg #(
      .PC_WIDTH    (PC_WIDTH),
      .INSTR_WIDTH (INSTR_WIDTH)
   ) u_if_id (
      .clk_i      (clk),
      .rst_i      (reset),
      .flush_i    (branch_ok),
      .load_i     (advance),
      .ready_i    (out_ready),
      .instr_i    (instruction),
      .pc_i       (pc_q),
      .can_load_o (can_load),
      .valid_o    (out_valid),
      .instr_o    (out_instr),
      .pc_o       (out_pc)
   );

   assign inst_addr   = pc_q;
   assign halted      = (state_q == ST_HALTED);
   assign fetch_count = cnt_q;

endmodule
